// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART definitions (receiver FSM states, default line settings).
//  UART_CLK_FREQ / UART_BAUD_RATE : default clocking shared with the transmitter
//  uart_rx_state_t                : receiver FSM state encoding
//  baud_div()                     : clocks per bit for a given clock and line rate
package uart_rx_pkg;

    localparam int UART_CLK_FREQ  = 20_000_000;
    localparam int UART_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } uart_rx_state_t;

    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte buffer interface between the UART receiver and its consumer.
//  Data      : received byte, stable while Valid=1
//  Valid     : byte available, held until Ack
//  Ack       : consumer takes Data (only meaningful while Valid=1)
//  Busy      : receiver is inside a frame or a line break
//  Frame_Err : one-cycle pulse on a bad stop bit
//  Overrun   : sticky, a byte was dropped because the buffer was still full
//  modport master : receiver side, modport slave : consumer side
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data;
    logic                 Valid;
    logic                 Ack;
    logic                 Busy;
    logic                 Frame_Err;
    logic                 Overrun;

    modport master (output Data, output Valid, output Busy, output Frame_Err, output Overrun,
                    input  Ack);
    modport slave  (input  Data, input  Valid, input  Busy, input  Frame_Err, input  Overrun,
                    output Ack);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: two-flop synchroniser for a single asynchronous input.
//  Clk  : destination clock
//  Rst  : synchronous active-high reset, loads RESET_VAL into both flops
//  din  : asynchronous input
//  dout : synchronised output (two clocks of latency)
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic din,
    output logic dout
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    assign dout = sync_r;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ack output buffer.
//  Clk : system clock, Rst : synchronous active-high reset
//  RXD : asynchronous serial input, idle high
//  bus : uart_rx_if master (Data, Valid, Ack, Busy, Frame_Err, Overrun)
// The start bit is confirmed at its midpoint; every later bit is sampled one bit period
// after the previous sample, so all samples land mid-bit. The byte is loaded into the
// output buffer at the stop-bit sample, giving Valid 2+HALF+DATA_BITS*DIV+DIV+1 clocks
// after the RXD falling edge.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = UART_CLK_FREQ,
    parameter int BAUD_RATE = UART_BAUD_RATE,
    parameter int DATA_BITS = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RXD,
    uart_rx_if.master  bus
);
    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    logic                 rxd_s;
    uart_rx_state_t       state_r;
    uart_rx_state_t       state_nxt_s;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 bit_tick_s;
    logic                 stop_ok_s;
    logic                 stop_bad_s;
    logic                 ack_s;

    assign ack_s = bus.Ack;

    uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .Clk  (Clk),
        .Rst  (Rst),
        .din  (RXD),
        .dout (rxd_s)
    );

    // Next-state decode and per-cycle sample strobes.
    always_comb begin
        state_nxt_s = state_r;
        bit_tick_s  = 1'b0;
        stop_ok_s   = 1'b0;
        stop_bad_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (!rxd_s) state_nxt_s = RX_START;
                else        state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                // A start bit that is gone by mid-bit is treated as a glitch.
                if (baud_cnt_r == HALF_LAST) state_nxt_s = rxd_s ? RX_IDLE : RX_DATA;
                else                         state_nxt_s = RX_START;
            end
            RX_DATA: begin
                bit_tick_s = (baud_cnt_r == DIV_LAST);
                if (bit_tick_s && (bit_idx_r == BIT_LAST)) state_nxt_s = RX_STOP;
                else                                       state_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (baud_cnt_r == DIV_LAST) begin
                    stop_ok_s   = rxd_s;
                    stop_bad_s  = !rxd_s;
                    state_nxt_s = rxd_s ? RX_IDLE : RX_BREAK;
                end else begin
                    state_nxt_s = RX_STOP;
                end
            end
            RX_BREAK: begin
                // A held-low line must return high before a new start can be seen.
                if (rxd_s) state_nxt_s = RX_IDLE;
                else       state_nxt_s = RX_BREAK;
            end
            default: state_nxt_s = RX_IDLE;
        endcase
    end

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r     <= RX_IDLE;
            busy_r      <= 1'b0;
            baud_cnt_r  <= CNT_ZERO;
            bit_idx_r   <= IDX_ZERO;
            shift_r     <= '0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != RX_IDLE);

            if ((state_nxt_s != state_r) || (state_r == RX_IDLE) || (state_r == RX_BREAK)) begin
                baud_cnt_r <= CNT_ZERO;
            end else if (baud_cnt_r == DIV_LAST) begin
                baud_cnt_r <= CNT_ZERO;
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_ONE;
            end

            if (state_r == RX_START) begin
                bit_idx_r <= IDX_ZERO;
            end else if (bit_tick_s) begin
                bit_idx_r <= (bit_idx_r == BIT_LAST) ? IDX_ZERO : (bit_idx_r + IDX_ONE);
            end

            // LSB arrives first, so shift in from the top.
            if (bit_tick_s) begin
                shift_r <= {rxd_s, shift_r[DATA_BITS-1:1]};
            end

            frame_err_r <= stop_bad_s;

            if (stop_ok_s) begin
                if (valid_r && !ack_s) begin
                    // Buffer still owned by the consumer: keep old byte, drop new one.
                    overrun_r <= 1'b1;
                end else begin
                    data_r  <= shift_r;
                    valid_r <= 1'b1;
                    if (valid_r) begin
                        overrun_r <= 1'b0;
                    end
                end
            end else if (valid_r && ack_s) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.Data      = data_r;
    assign bus.Valid     = valid_r;
    assign bus.Busy      = busy_r;
    assign bus.Frame_Err = frame_err_r;
    assign bus.Overrun   = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at DIV=16 (1.6 MHz clock, 100 kbit/s).
// Expected bytes go into a scoreboard queue when a frame is driven and are popped when
// the receiver raises Valid. Inputs change on the falling clock edge; outputs are sampled there.
module tb_uart_rx;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic RXD = 1'b1;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ferr_cnt = 0;

    logic [7:0] exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) bus_if ();

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .RXD (RXD),
        .bus (bus_if)
    );

    always #5 Clk = ~Clk;

    // Count cycles in which Frame_Err is high.
    always @(negedge Clk) begin
        if (bus_if.Frame_Err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Drive one frame: start bit, 8 data bits LSB first, then the given stop level (16 clocks each).
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic push);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        if (push && stop) exp_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            RXD = frame[i];
            repeat (15) @(negedge Clk);
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus_if.Valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic pulse_ack();
        @(negedge Clk);
        bus_if.Ack = 1'b1;
        @(negedge Clk);
        bus_if.Ack = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; RXD = 1'b1; bus_if.Ack = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk_cnt++; if (bus_if.Data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus_if.Data); else pass_cnt++;
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_if.Valid); else pass_cnt++;
        chk_cnt++; if (bus_if.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_if.Busy); else pass_cnt++;
        chk_cnt++; if (bus_if.Frame_Err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", bus_if.Frame_Err); else pass_cnt++;
        chk_cnt++; if (bus_if.Overrun !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", bus_if.Overrun); else pass_cnt++;
    endtask

    task automatic test_basic_latency();
        int lat;
        int f0;
        logic [7:0] exp;
        f0 = ferr_cnt;
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge Clk);
                while (bus_if.Valid !== 1'b1 && lat < 300) begin
                    @(negedge Clk);
                    lat++;
                end
            end
        join
        chk_cnt++; if (lat !== 155) $display("FAIL basic_latency: got %0d expected 155", lat); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk_cnt++; if (bus_if.Data !== exp) $display("FAIL basic_data: got %h expected %h", bus_if.Data, exp); else pass_cnt++;
        chk_cnt++; if (ferr_cnt !== f0) $display("FAIL basic_ferr: got %0d expected %0d", ferr_cnt, f0); else pass_cnt++;
        pulse_ack();
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL basic_ack: got %b expected 0", bus_if.Valid); else pass_cnt++;
    endtask

    task automatic test_glitch();
        bit busy_seen;
        int f0;
        f0 = ferr_cnt;
        busy_seen = 1'b0;
        @(negedge Clk);
        RXD = 1'b0;
        repeat (4) @(negedge Clk);
        RXD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus_if.Busy === 1'b1) busy_seen = 1'b1;
        end
        chk_cnt++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen); else pass_cnt++;
        chk_cnt++; if (bus_if.Busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", bus_if.Busy); else pass_cnt++;
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL glitch_valid: got %b expected 0", bus_if.Valid); else pass_cnt++;
        chk_cnt++; if (ferr_cnt !== f0) $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); else pass_cnt++;
        chk_cnt++; if (bus_if.Overrun !== 1'b0) $display("FAIL glitch_ovr: got %b expected 0", bus_if.Overrun); else pass_cnt++;
    endtask

    task automatic test_frame_error();
        int f0;
        int waited;
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, 1'b1);
        repeat (40) @(negedge Clk);
        chk_cnt++; if (bus_if.Busy !== 1'b1) $display("FAIL ferr_busy_break: got %b expected 1", bus_if.Busy); else pass_cnt++;
        RXD = 1'b1;
        waited = 0;
        while (bus_if.Busy === 1'b1 && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        chk_cnt++; if (bus_if.Busy !== 1'b0) $display("FAIL ferr_busy_release: got %b expected 0", bus_if.Busy); else pass_cnt++;
        chk_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse_cycles: got %0d expected 1", ferr_cnt - f0); else pass_cnt++;
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL ferr_valid: got %b expected 0", bus_if.Valid); else pass_cnt++;
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] exp;
        send_byte(8'h11, 1'b1, 1'b1);
        wait_valid(50, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL ovr_first_valid: got %b expected 1", ok); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk_cnt++; if (bus_if.Data !== exp) $display("FAIL ovr_first_data: got %h expected %h", bus_if.Data, exp); else pass_cnt++;
        send_byte(8'h22, 1'b1, 1'b0);
        chk_cnt++; if (bus_if.Data !== 8'h11) $display("FAIL ovr_data_kept: got %h expected 11", bus_if.Data); else pass_cnt++;
        chk_cnt++; if (bus_if.Overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", bus_if.Overrun); else pass_cnt++;
        pulse_ack();
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b expected 0", bus_if.Valid); else pass_cnt++;
        chk_cnt++; if (bus_if.Overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b expected 0", bus_if.Overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back_ack();
        bit ok;
        logic [7:0] exp;
        send_byte(8'h11, 1'b1, 1'b1);
        wait_valid(50, ok);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk_cnt++; if (ok !== 1'b1 || bus_if.Data !== exp) $display("FAIL b2b_first: got %b/%h expected 1/%h", ok, bus_if.Data, exp); else pass_cnt++;
        fork
            send_byte(8'h22, 1'b1, 1'b1);
            begin
                @(negedge Clk);
                repeat (154) @(negedge Clk);
                chk_cnt++; if (bus_if.Data !== 8'h11) $display("FAIL b2b_before_commit: got %h expected 11", bus_if.Data); else pass_cnt++;
                bus_if.Ack = 1'b1;
                @(negedge Clk);
                bus_if.Ack = 1'b0;
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk_cnt++; if (bus_if.Data !== exp) $display("FAIL b2b_data: got %h expected %h", bus_if.Data, exp); else pass_cnt++;
        chk_cnt++; if (bus_if.Valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", bus_if.Valid); else pass_cnt++;
        chk_cnt++; if (bus_if.Overrun !== 1'b0) $display("FAIL b2b_ovr: got %b expected 0", bus_if.Overrun); else pass_cnt++;
    endtask

    task automatic test_mid_frame_reset();
        bit ok;
        int f0;
        logic [7:0] exp;
        // Buffer still holds the previous byte here, so the reset has something to clear.
        fork
            send_byte(8'h77, 1'b1, 1'b0);
            begin
                @(negedge Clk);
                repeat (136) @(negedge Clk);
                Rst = 1'b1;
                @(negedge Clk);
                Rst = 1'b0;
                chk_cnt++; if (bus_if.Data !== 8'h00) $display("FAIL rst_mid_data: got %h expected 00", bus_if.Data); else pass_cnt++;
                chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", bus_if.Valid); else pass_cnt++;
                chk_cnt++; if (bus_if.Busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", bus_if.Busy); else pass_cnt++;
                chk_cnt++; if (bus_if.Overrun !== 1'b0) $display("FAIL rst_mid_ovr: got %b expected 0", bus_if.Overrun); else pass_cnt++;
            end
        join
        f0 = ferr_cnt;
        repeat (20) @(negedge Clk);
        chk_cnt++; if (bus_if.Valid !== 1'b0) $display("FAIL rst_no_partial: got %b expected 0", bus_if.Valid); else pass_cnt++;
        send_byte(8'h5A, 1'b1, 1'b1);
        wait_valid(50, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL rst_next_valid: got %b expected 1", ok); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk_cnt++; if (bus_if.Data !== exp) $display("FAIL rst_next_data: got %h expected %h", bus_if.Data, exp); else pass_cnt++;
        chk_cnt++; if (ferr_cnt !== f0) $display("FAIL rst_next_ferr: got %0d expected %0d", ferr_cnt, f0); else pass_cnt++;
        pulse_ack();
    endtask

    initial begin
        bus_if.Ack = 1'b0;
        test_reset();
        test_basic_latency();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back_ack();
        test_mid_frame_reset();
        chk_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
